cpu_bus_sequencer: RTL and testbench
====================================

Name: cpu_bus_sequencer

Overview:
Upstream stage of the SDRAM controller.
- Generates the 65816 PHI2 clock from the 166.666 MHz system clock.
- Demultiplexes the bank byte from the CPU data bus during PHI1, decodes the RAM window, and presents a stable address, direction, chip select and write data to the SDRAM controller for the whole PHI2 high phase.
- Holds the CPU in reset until SDRAM initialisation completes, and steers read data back onto the CPU data bus.

Parameters:
PHI1_CYCLES, 8, clk cycles PHI2 is low per bus cycle (must be >= 2)
PHI2_CYCLES, 16, clk cycles PHI2 is high per bus cycle (must be >= 12: covers activate + read/write + refresh)
RESET_PHI_CYCLES, 2, complete PHI2 periods cpu_res_n stays low after ram_ready
RAM_BANK_LIMIT, 8'h7F, highest bank (inclusive) decoded as SDRAM

Ports:
clk  in  1  system clock, 166.666 MHz
reset_n  in  1  asynchronous active-low reset
ram_ready  in  1  SDRAM initialisation complete
cpu_addr  in  16  CPU A15..A0
cpu_data_in  in  8  CPU D7..D0 (bank byte in PHI1, write data in PHI2)
cpu_data_out  out  8  read data to CPU
cpu_data_oe  out  1  drive cpu_data_out onto CPU bus
cpu_rwb  in  1  CPU read/write, high = read
cpu_vda  in  1  valid data address
cpu_vpa  in  1  valid program address
cpu_phi2  out  1  PHI2 clock to CPU
cpu_res_n  out  1  CPU reset, active low
phi2  out  1  bus cycle sync to SDRAM controller (same as cpu_phi2)
read_write  out  1  latched direction to controller
cs_n  out  1  latched RAM select to controller, active low
address  out  25  {byte lane, word address} to controller
data_in  out  8  write data to controller
ram_data  in  8  read data from controller

Behaviour:
- Reset (reset_n low, asynchronous) forces the following outputs: state HOLD, phi2 0, cpu_res_n 0, cs_n 1, read_write 1, address 0, data_in 0, cpu_data_oe 0, cpu_data_out 0, all counters 0.
- FSM states: HOLD, PHI1, PHI2.
  - HOLD: phi2 low; cs_n 1. Moves to PHI1 on the first clk with ram_ready high.
  - PHI1: phi_counter counts 0..PHI1_CYCLES-1; phi2 low.
    - On the edge where the counter equals PHI1_CYCLES-1, the next state is PHI2 and the bus latch is captured on that same edge.
    - Captured values: bank <= cpu_data_in; addr <= cpu_addr; read_write <= cpu_rwb; cs_n <= !((cpu_vda|cpu_vpa) && cpu_res_n && cpu_data_in <= RAM_BANK_LIMIT).
    - Result: the latch is stable in the first clk with phi2 high, when the controller detects the rising edge.
  - PHI2: phi_counter counts 0..PHI2_CYCLES-1; phi2 high.
    - At the final count, the next state is PHI1, or HOLD if ram_ready is low.
    - On exit, cs_n <= 1 and read_write <= 1.
- Address mapping: 24-bit byte address A = {bank, addr}. address = {A[0], 1'b0, A[23:1]}.
  - Bit 24 selects the byte lane. Bits 23:0 form the word address.
- Write data: in PHI2 with read_write low, data_in <= cpu_data_in every clk. It holds its value otherwise.
- Read path:
  - cpu_data_out <= ram_data every clk in PHI2.
  - cpu_data_oe = 1 only in PHI2, when cs_n==0 and read_write==1.
  - cpu_data_oe is never high in PHI1 or HOLD, because the bank byte uses the bus then.
- CPU reset:
  - reset_count increments at each PHI2 exit while cpu_res_n is low.
  - cpu_res_n is released when reset_count reaches RESET_PHI_CYCLES.
  - While cpu_res_n is low, cs_n stays 1.
- ram_ready falling:
  - The current PHI2 phase completes at full length; it is never truncated.
  - The FSM then enters HOLD, cpu_res_n <= 0 and reset_count <= 0.
  - Any PHI1 in progress completes first and its PHI2 runs.
- Bus period is PHI1_CYCLES+PHI2_CYCLES clk (24 by default, about 6.94 MHz). Duty cycle is fixed and there is no stretching.
- No stretching is needed because the controller's worst case is read or write followed by refresh (<= 21 clk). This fits between consecutive PHI2 rising edges.
- All outputs are registered. The only exception is cpu_data_oe, which is decoded from registered state.

Decomposition:
- Package zeus_bus_pkg holds:
  - the bus_state_t enum {HOLD, PHI1, PHI2};
  - a function map_ram_address(bank, addr) returning the 25-bit controller address;
  - the constant RAM_ADDR_W = 25.
- No sub-module is needed. The phase counter and FSM stay in this block.

Test Plan:
- Reset release with ram_ready low for 100 clk -> phi2 stays 0, cpu_res_n 0, cs_n 1. After ram_ready rises: phi2 low 8 clk, then high 16 clk, and cpu_res_n rises at the end of the 2nd PHI2 phase.
- Read: bank 8'h12 in PHI1, cpu_addr 16'h3457, rwb 1, vda 1 -> address 25'h1_091A2B and cs_n 0 in the first PHI2 clk. ram_data 8'hA5 -> cpu_data_out A5 with cpu_data_oe 1 during PHI2 only.
- Write: bank 8'h00, cpu_addr 16'h0100, rwb 0, cpu_data_in 8'h5A in PHI2 -> read_write 0, address 25'h0_000080, data_in 5A, cpu_data_oe 0 throughout.
- Bank 8'h80 (above RAM_BANK_LIMIT), or vda=vpa=0 -> cs_n stays 1 for the whole cycle and cpu_data_oe 0.
- ram_ready drops mid-PHI2 -> PHI2 still lasts 16 clk, then HOLD with cpu_res_n 0. On ram_ready return, the 2-period reset sequence repeats.
- reset_n asserted mid-PHI2 -> phi2, cpu_res_n and cs_n go to their reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/zeus_bus_pkg.sv
// Shared types and address mapping for the 65816 bus front end of the SDRAM controller.
package zeus_bus_pkg;

    localparam int RAM_ADDR_W = 25;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        PHI1 = 2'd1,
        PHI2 = 2'd2
    } bus_state_t;

    // Byte address {bank, addr} becomes {byte lane, word address}; bit 23 of the word address is always 0.
    function automatic logic [RAM_ADDR_W-1:0] map_ram_address(input logic [7:0] bank, input logic [15:0] addr);
        logic [23:0] byte_addr;
        byte_addr = {bank, addr};
        return {byte_addr[0], 1'b0, byte_addr[23:1]};
    endfunction

endpackage

// File: rtl/cpu_bus_sequencer.sv
// Generates PHI2 for the 65816, latches the demultiplexed bus for the SDRAM controller and sequences CPU reset.
module cpu_bus_sequencer
    import zeus_bus_pkg::*;
#(
    parameter int          PHI1_CYCLES      = 8,
    parameter int          PHI2_CYCLES      = 16,
    parameter int          RESET_PHI_CYCLES = 2,
    parameter logic [7:0]  RAM_BANK_LIMIT   = 8'h7F
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ram_ready,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_data_oe,
    input  logic                  cpu_rwb,
    input  logic                  cpu_vda,
    input  logic                  cpu_vpa,
    output logic                  cpu_phi2,
    output logic                  cpu_res_n,
    output logic                  phi2,
    output logic                  read_write,
    output logic                  cs_n,
    output logic [RAM_ADDR_W-1:0] address,
    output logic [7:0]            data_in,
    input  logic [7:0]            ram_data,
    output logic [1:0]            state_dbg
);

    localparam int PHI_MAX = (PHI1_CYCLES > PHI2_CYCLES) ? PHI1_CYCLES : PHI2_CYCLES;
    localparam int CNT_W   = $clog2(PHI_MAX);
    localparam int RC_W    = $clog2(RESET_PHI_CYCLES + 2);

    localparam logic [CNT_W-1:0] PHI1_LAST = CNT_W'(PHI1_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHI2_LAST = CNT_W'(PHI2_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RESET_PHI_CYCLES - 1);

    bus_state_t       state;
    logic [CNT_W-1:0] phi_counter;
    logic [RC_W-1:0]  reset_count;

    // Controller handshake: phi2 high is the strobe. address, cs_n and read_write are valid from the
    // first clk of phi2 high and stay constant until phi2 falls; the controller must finish its access
    // (and any refresh) before the next rising edge. There is no back-pressure.
    assign cpu_phi2    = phi2;
    assign state_dbg   = state;
    assign cpu_data_oe = (state == PHI2) && !cs_n && read_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= HOLD;
            phi_counter  <= '0;
            reset_count  <= '0;
            phi2         <= 1'b0;
            cpu_res_n    <= 1'b0;
            cs_n         <= 1'b1;
            read_write   <= 1'b1;
            address      <= '0;
            data_in      <= '0;
            cpu_data_out <= '0;
        end else begin
            case (state)
                HOLD: begin
                    phi_counter <= '0;
                    if (ram_ready) begin
                        state <= PHI1;
                    end
                end
                PHI1: begin
                    if (phi_counter == PHI1_LAST) begin
                        // Bank byte is still on the data bus here; capture everything on the same edge.
                        state       <= PHI2;
                        phi_counter <= '0;
                        phi2        <= 1'b1;
                        address     <= map_ram_address(cpu_data_in, cpu_addr);
                        read_write  <= cpu_rwb;
                        cs_n        <= !((cpu_vda || cpu_vpa) && cpu_res_n && (cpu_data_in <= RAM_BANK_LIMIT));
                    end else begin
                        phi_counter <= phi_counter + CNT_W'(1);
                    end
                end
                PHI2: begin
                    cpu_data_out <= ram_data;
                    if (!read_write) begin
                        data_in <= cpu_data_in;
                    end
                    if (phi_counter == PHI2_LAST) begin
                        phi_counter <= '0;
                        phi2        <= 1'b0;
                        cs_n        <= 1'b1;
                        read_write  <= 1'b1;
                        if (!ram_ready) begin
                            state       <= HOLD;
                            cpu_res_n   <= 1'b0;
                            reset_count <= '0;
                        end else begin
                            state <= PHI1;
                            if (!cpu_res_n) begin
                                reset_count <= reset_count + RC_W'(1);
                                if (reset_count == RC_LAST) begin
                                    cpu_res_n <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        phi_counter <= phi_counter + CNT_W'(1);
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomised bus-cycle bench for cpu_bus_sequencer with an expected-transaction queue and a phi2-driven monitor.
module tb_cpu_bus_sequencer;

    localparam int W         = 45;
    localparam int N_CYCLES  = 40;
    localparam int LOW_LEN   = 8;
    localparam int HIGH_LEN  = 16;
    localparam int RESET_PHI = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ram_ready;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_rwb;
    logic        cpu_vda;
    logic        cpu_vpa;
    logic        cpu_phi2;
    logic        cpu_res_n;
    logic        phi2;
    logic        read_write;
    logic        cs_n;
    logic [24:0] address;
    logic [7:0]  data_in;
    logic [7:0]  ram_data;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;
    bit           have_cur = 0;
    bit           mon_en = 1;
    bit           prev_phi2 = 0;
    int           low_run = 0;
    int           high_run = 0;
    int           k = 0;

    cpu_bus_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ram_ready    (ram_ready),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_rwb      (cpu_rwb),
        .cpu_vda      (cpu_vda),
        .cpu_vpa      (cpu_vpa),
        .cpu_phi2     (cpu_phi2),
        .cpu_res_n    (cpu_res_n),
        .phi2         (phi2),
        .read_write   (read_write),
        .cs_n         (cs_n),
        .address      (address),
        .data_in      (data_in),
        .ram_data     (ram_data),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    always #3 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference address mapping from plain arithmetic on the 24-bit byte address.
    function automatic logic [24:0] model_addr(input logic [7:0] bank, input logic [15:0] a);
        int unsigned byte_a;
        byte_a = int'(bank) * 65536 + int'(a);
        return 25'((byte_a % 2) * (1 << 24) + byte_a / 2);
    endfunction

    task automatic wait_phi2(input logic level, input string what);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (phi2 === level);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: phi2 did not reach %0b within 200 clk, got %0b", what, level, phi2);
        end
    endtask

    // One bus cycle: drive PHI1 inputs, push the expectation, then drive PHI2 data.
    task automatic run_cycle(input logic [7:0] bank, input logic [15:0] a, input logic rwb,
                             input logic vda, input logic vpa, input logic [7:0] wd,
                             input logic [7:0] rd, input bit drop);
        logic exp_res_during, exp_res_after, exp_cs;
        exp_res_during = (k >= RESET_PHI);
        exp_res_after  = drop ? 1'b0 : (k + 1 >= RESET_PHI);
        exp_cs         = !((vda || vpa) && exp_res_during && bank <= 8'h7F);
        cpu_data_in = bank;
        cpu_addr    = a;
        cpu_rwb     = rwb;
        cpu_vda     = vda;
        cpu_vpa     = vpa;
        ram_data    = 8'($urandom);
        exp_q.push_back({exp_cs, rwb, exp_res_during, exp_res_after, model_addr(bank, a), wd, rd});
        if (!ram_ready) begin
            ram_ready = 1'b1;
        end
        wait_phi2(1'b1, "phi2_rise_timeout");
        cpu_data_in = wd;
        ram_data    = rd;
        if (drop) begin
            repeat (5) @(negedge clk);
            #1;
            ram_ready = 1'b0;
        end
        wait_phi2(1'b0, "phi2_fall_timeout");
        if (drop) begin
            repeat (30) begin
                @(negedge clk);
                #1;
                check("hold_phi2", phi2, 1'b0);
            end
            check("hold_res_n", cpu_res_n, 1'b0);
            check("hold_cs_n", cs_n, 1'b1);
            k = 0;
        end else begin
            k++;
        end
    endtask

    // Monitor: pops one expectation per phi2 rising edge and checks the whole bus cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (phi2 && !prev_phi2) begin
                check("low_len", low_run, LOW_LEN);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cycle: phi2 rose with empty expected queue at %0t", $time);
                    have_cur = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    check("cs_n", cs_n, cur[44]);
                    check("read_write", read_write, cur[43]);
                    check("res_n_in_phi2", cpu_res_n, cur[42]);
                    check("address", address, cur[40:16]);
                end
                high_run = 1;
            end else if (phi2) begin
                high_run++;
            end
            if (phi2 && have_cur) begin
                check("oe_phi2", cpu_data_oe, !cur[44] && cur[43]);
            end
            if (!phi2 && prev_phi2) begin
                check("high_len", high_run, HIGH_LEN);
                check("exit_cs_n", cs_n, 1'b1);
                check("exit_read_write", read_write, 1'b1);
                if (have_cur) begin
                    check("res_n_after", cpu_res_n, cur[41]);
                    check("cpu_data_out", cpu_data_out, cur[7:0]);
                    if (!cur[43]) begin
                        check("data_in", data_in, cur[15:8]);
                    end
                end
                have_cur = 0;
                low_run = 0;
            end
            if (!phi2) begin
                if (ram_ready) begin
                    low_run++;
                end
                check("oe_low", cpu_data_oe, 1'b0);
            end
            prev_phi2 = phi2;
        end
    end

    // Stimulus
    initial begin
        logic [7:0]  bank, wd, rd;
        logic [15:0] a;
        logic        rwb, vda, vpa;
        bit          drop;

        reset_n     = 1'b1;
        ram_ready   = 1'b0;
        cpu_addr    = '0;
        cpu_data_in = '0;
        cpu_rwb     = 1'b1;
        cpu_vda     = 1'b0;
        cpu_vpa     = 1'b0;
        ram_data    = '0;
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_phi2", phi2, 1'b0);
        check("rst_cpu_phi2", cpu_phi2, 1'b0);
        check("rst_res_n", cpu_res_n, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_read_write", read_write, 1'b1);
        check("rst_address", address, 25'd0);
        check("rst_data_in", data_in, 8'd0);
        check("rst_data_out", cpu_data_out, 8'd0);
        check("rst_oe", cpu_data_oe, 1'b0);
        #1;
        reset_n = 1'b1;

        repeat (100) begin
            @(negedge clk);
            #1;
            check("idle_hold", {phi2, cpu_res_n, cs_n}, 3'b001);
        end

        for (int g = 0; g < N_CYCLES; g++) begin
            bank = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
            a    = 16'($urandom);
            rwb  = 1'($urandom);
            vda  = ($urandom_range(0, 3) != 0);
            vpa  = 1'($urandom);
            wd   = 8'($urandom);
            rd   = 8'($urandom);
            drop = (g == 8) || (g > 10 && g < N_CYCLES - 4 && $urandom_range(0, 7) == 0);
            case (g)
                2: begin bank = 8'h12; a = 16'h3457; rwb = 1'b1; vda = 1'b1; vpa = 1'b0; rd = 8'hA5; end
                3: begin bank = 8'h00; a = 16'h0100; rwb = 1'b0; vda = 1'b1; vpa = 1'b0; wd = 8'h5A; end
                4: begin bank = 8'h80; rwb = 1'b1; vda = 1'b1; vpa = 1'b1; end
                5: begin bank = 8'h10; rwb = 1'b1; vda = 1'b0; vpa = 1'b0; end
                default: ;
            endcase
            run_cycle(bank, a, rwb, vda, vpa, wd, rd, drop);
        end
        check("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a selected read PHI2 phase.
        mon_en      = 0;
        cpu_data_in = 8'h12;
        cpu_addr    = 16'h3457;
        cpu_rwb     = 1'b1;
        cpu_vda     = 1'b1;
        cpu_vpa     = 1'b0;
        wait_phi2(1'b1, "final_rise_timeout");
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_phi2", phi2, 1'b1);
        check("pre_reset_cs_n", cs_n, 1'b0);
        check("pre_reset_oe", cpu_data_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_phi2", phi2, 1'b0);
        check("async_res_n", cpu_res_n, 1'b0);
        check("async_cs_n", cs_n, 1'b1);
        check("async_address", address, 25'd0);
        check("async_oe", cpu_data_oe, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
